// File: rtl/instruction_fetch.sv
// Fetch stage: holds the program counter, issues one word read at a time to
// instruction memory over req/ack, and presents one 16-bit instruction with a
// valid flag to the decoder. Handles stall, branch redirect, HALT and RESET
// commands from downstream.
module instruction_fetch #(
    parameter int                  PC_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk_pi,
    input  logic                reset_n_pi,
    output logic                imem_req_po,
    output logic [PC_WIDTH-1:0] imem_addr_po,
    input  logic                imem_ack_pi,
    input  logic [15:0]         imem_data_pi,
    input  logic                stall_pi,
    input  logic                redirect_pi,
    input  logic [PC_WIDTH-1:0] redirect_target_pi,
    input  logic                halt_cmd_pi,
    input  logic                rst_cmd_pi,
    output logic [15:0]         instruction_po,
    output logic                instr_valid_po,
    output logic [PC_WIDTH-1:0] pc_po,
    output logic                halted_po
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] FETCH  = 2'd1;
    localparam logic [1:0] HOLD   = 2'd2;
    localparam logic [1:0] HALTED = 2'd3;

    localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]          state;
    logic [PC_WIDTH-1:0] pc_q;      // address of the next fetch
    logic                squash_q;  // in-flight read must be discarded
    logic [PC_WIDTH-1:0] tgt_q;     // redirect target captured mid-request

    // The request and its address decode straight from state, so an async
    // reset drops the request immediately and the address never moves while
    // a request is pending (pc_q only changes on ack).
    assign imem_req_po  = (state == FETCH);
    assign imem_addr_po = pc_q;

    // Fetch state machine and the registered decoder-facing outputs.
    always_ff @(posedge clk_pi or negedge reset_n_pi) begin
        if (!reset_n_pi) begin
            state          <= IDLE;
            pc_q           <= RESET_PC;
            squash_q       <= 1'b0;
            tgt_q          <= '0;
            instruction_po <= 16'h0000;
            instr_valid_po <= 1'b0;
            pc_po          <= '0;
            halted_po      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state <= FETCH;
                end

                FETCH: begin
                    if (imem_ack_pi) begin
                        if (squash_q || redirect_pi) begin
                            // Stale data: drop it and restart at the target.
                            pc_q     <= redirect_pi ? redirect_target_pi : tgt_q;
                            squash_q <= 1'b0;
                        end else begin
                            instruction_po <= imem_data_pi;
                            instr_valid_po <= 1'b1;
                            pc_po          <= pc_q;
                            pc_q           <= pc_q + PC_ONE;
                            state          <= HOLD;
                        end
                    end else if (redirect_pi) begin
                        // Cannot abandon the pending read; remember where to go.
                        squash_q <= 1'b1;
                        tgt_q    <= redirect_target_pi;
                    end
                end

                HOLD: begin
                    if (redirect_pi) begin
                        pc_q           <= redirect_target_pi;
                        instruction_po <= 16'h0000;
                        instr_valid_po <= 1'b0;
                        state          <= FETCH;
                    end else if (!stall_pi) begin
                        instruction_po <= 16'h0000;
                        instr_valid_po <= 1'b0;
                        if (rst_cmd_pi) begin
                            pc_q  <= RESET_PC;
                            state <= FETCH;
                        end else if (halt_cmd_pi) begin
                            halted_po <= 1'b1;
                            state     <= HALTED;
                        end else begin
                            state <= FETCH;
                        end
                    end
                end

                default: begin
                    // HALTED: only reset_n_pi gets us out.
                    state <= HALTED;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed testbench for instruction_fetch with a simple memory model whose
// ack latency is adjustable and whose data is addr + 16'h1000 (or a fixed
// override word).
module tb_instruction_fetch;

    logic        clk;
    logic        reset_n;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_data;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_target;
    logic        halt_cmd;
    logic        rst_cmd;
    logic [15:0] instruction;
    logic        instr_valid;
    logic [15:0] pc;
    logic        halted;

    int          checks;
    int          passed;

    // memory model controls
    int          mem_lat;
    int          wait_cnt;
    logic        ovr_en;
    logic [15:0] ovr_val;

    instruction_fetch #(.PC_WIDTH(16), .RESET_PC(16'h0000)) dut (
        .clk_pi             (clk),
        .reset_n_pi         (reset_n),
        .imem_req_po        (imem_req),
        .imem_addr_po       (imem_addr),
        .imem_ack_pi        (imem_ack),
        .imem_data_pi       (imem_data),
        .stall_pi           (stall),
        .redirect_pi        (redirect),
        .redirect_target_pi (redirect_target),
        .halt_cmd_pi        (halt_cmd),
        .rst_cmd_pi         (rst_cmd),
        .instruction_po     (instruction),
        .instr_valid_po     (instr_valid),
        .pc_po              (pc),
        .halted_po          (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign imem_ack  = imem_req && (wait_cnt >= mem_lat);
    assign imem_data = ovr_en ? ovr_val : (imem_addr + 16'h1000);

    // count cycles the current request has been pending
    always @(posedge clk) begin
        if (!imem_req || imem_ack) wait_cnt <= 0;
        else                       wait_cnt <= wait_cnt + 1;
    end

    // one line per completed memory transaction
    always @(negedge clk) begin
        if (imem_req && imem_ack)
            $display("txn: read addr=%h data=%h", imem_addr, imem_data);
    end

    task automatic test_reset();
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if ({imem_req, instr_valid, instruction, pc, halted} !== {1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0})
            $display("FAIL reset_state: req=%b valid=%b instr=%h pc=%h halted=%b, need all zero",
                     imem_req, instr_valid, instruction, pc, halted);
        else passed++;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        checks++;
        if (imem_req !== 1'b0) $display("FAIL idle_no_req: req=%b need 0", imem_req);
        else passed++;
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({imem_req, imem_addr, instr_valid} !== {1'b1, 16'(i), 1'b0})
                $display("FAIL seq_req%0d: req=%b addr=%h valid=%b need 1 %h 0", i, imem_req, imem_addr, instr_valid, 16'(i));
            else passed++;
            @(negedge clk);
            checks++;
            if ({instr_valid, instruction, pc, imem_req} !== {1'b1, 16'h1000 + 16'(i), 16'(i), 1'b0})
                $display("FAIL seq_present%0d: valid=%b instr=%h pc=%h req=%b need 1 %h %h 0",
                         i, instr_valid, instruction, pc, imem_req, 16'h1000 + 16'(i), 16'(i));
            else passed++;
        end
    endtask

    task automatic test_stall();
        reset_n = 1'b0;
        #1;
        stall   = 1'b1;
        ovr_en  = 1'b1;
        ovr_val = 16'h1234;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 16'h0000})
            $display("FAIL stall_first_req: req=%b addr=%h need 1 0000", imem_req, imem_addr);
        else passed++;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({instr_valid, instruction, pc, imem_req} !== {1'b1, 16'h1234, 16'h0000, 1'b0})
                $display("FAIL stall_hold%0d: valid=%b instr=%h pc=%h req=%b need 1 1234 0000 0",
                         i, instr_valid, instruction, pc, imem_req);
            else passed++;
            if (i < 3) @(negedge clk);
        end
        stall = 1'b0;
        @(negedge clk);
        ovr_en = 1'b0;
        checks++;
        if ({imem_req, imem_addr, instr_valid} !== {1'b1, 16'h0001, 1'b0})
            $display("FAIL stall_release: req=%b addr=%h valid=%b need 1 0001 0", imem_req, imem_addr, instr_valid);
        else passed++;
        @(negedge clk);
        checks++;
        if ({instr_valid, instruction, pc} !== {1'b1, 16'h1001, 16'h0001})
            $display("FAIL stall_next_instr: valid=%b instr=%h pc=%h need 1 1001 0001", instr_valid, instruction, pc);
        else passed++;
    endtask

    task automatic test_redirect_in_fetch();
        // from HOLD, jump to 5 and slow the memory to 4 wait cycles
        redirect        = 1'b1;
        redirect_target = 16'h0005;
        mem_lat         = 4;
        @(negedge clk);
        redirect = 1'b0;
        checks++;
        if ({imem_req, imem_addr, imem_ack, instr_valid} !== {1'b1, 16'h0005, 1'b0, 1'b0})
            $display("FAIL rdf_req5: req=%b addr=%h ack=%b valid=%b need 1 0005 0 0", imem_req, imem_addr, imem_ack, instr_valid);
        else passed++;
        @(negedge clk);
        redirect        = 1'b1;
        redirect_target = 16'h0040;
        @(negedge clk);
        redirect = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({imem_req, imem_addr, instr_valid} !== {1'b1, 16'h0005, 1'b0})
                $display("FAIL rdf_addr_hold%0d: req=%b addr=%h valid=%b need 1 0005 0", i, imem_req, imem_addr, instr_valid);
            else passed++;
            if (i < 2) @(negedge clk);
        end
        checks++;
        if (imem_ack !== 1'b1) $display("FAIL rdf_ack_seen: ack=%b need 1", imem_ack);
        else passed++;
        @(negedge clk);
        mem_lat = 0;
        checks++;
        if ({imem_req, imem_addr, instr_valid} !== {1'b1, 16'h0040, 1'b0})
            $display("FAIL rdf_target_req: req=%b addr=%h valid=%b need 1 0040 0", imem_req, imem_addr, instr_valid);
        else passed++;
        @(negedge clk);
        checks++;
        if ({instr_valid, instruction, pc} !== {1'b1, 16'h1040, 16'h0040})
            $display("FAIL rdf_target_instr: valid=%b instr=%h pc=%h need 1 1040 0040", instr_valid, instruction, pc);
        else passed++;
    endtask

    task automatic test_halt();
        halt_cmd = 1'b1;
        @(negedge clk);
        halt_cmd = 1'b0;
        checks++;
        if ({halted, instr_valid, instruction, imem_req} !== {1'b1, 1'b0, 16'h0000, 1'b0})
            $display("FAIL halt_enter: halted=%b valid=%b instr=%h req=%b need 1 0 0000 0",
                     halted, instr_valid, instruction, imem_req);
        else passed++;
        redirect        = 1'b1;
        rst_cmd         = 1'b1;
        redirect_target = 16'h0123;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if ({halted, instr_valid, imem_req} !== {1'b1, 1'b0, 1'b0})
                $display("FAIL halt_sticky%0d: halted=%b valid=%b req=%b need 1 0 0", i, halted, instr_valid, imem_req);
            else passed++;
        end
        redirect = 1'b0;
        rst_cmd  = 1'b0;
        reset_n  = 1'b0;
        #1;
        checks++;
        if ({halted, imem_req, instr_valid} !== {1'b0, 1'b0, 1'b0})
            $display("FAIL halt_reset_async: halted=%b req=%b valid=%b need 0 0 0", halted, imem_req, instr_valid);
        else passed++;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({imem_req, imem_addr, halted} !== {1'b1, 16'h0000, 1'b0})
            $display("FAIL halt_restart: req=%b addr=%h halted=%b need 1 0000 0", imem_req, imem_addr, halted);
        else passed++;
    endtask

    task automatic test_rst_cmd();
        @(negedge clk);
        redirect        = 1'b1;
        redirect_target = 16'h0010;
        @(negedge clk);
        redirect = 1'b0;
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 16'h0010})
            $display("FAIL rst_to_10: req=%b addr=%h need 1 0010", imem_req, imem_addr);
        else passed++;
        @(negedge clk);
        checks++;
        if ({instr_valid, instruction, pc} !== {1'b1, 16'h1010, 16'h0010})
            $display("FAIL rst_hold10: valid=%b instr=%h pc=%h need 1 1010 0010", instr_valid, instruction, pc);
        else passed++;
        rst_cmd = 1'b1;
        @(negedge clk);
        rst_cmd = 1'b0;
        checks++;
        if ({imem_req, imem_addr, instr_valid} !== {1'b1, 16'h0000, 1'b0})
            $display("FAIL rst_cmd_pc: req=%b addr=%h valid=%b need 1 0000 0", imem_req, imem_addr, instr_valid);
        else passed++;
        @(negedge clk);
        redirect        = 1'b1;
        redirect_target = 16'h0020;
        halt_cmd        = 1'b1;
        @(negedge clk);
        redirect = 1'b0;
        halt_cmd = 1'b0;
        checks++;
        if ({halted, imem_req, imem_addr, instr_valid} !== {1'b0, 1'b1, 16'h0020, 1'b0})
            $display("FAIL redirect_beats_halt: halted=%b req=%b addr=%h valid=%b need 0 1 0020 0",
                     halted, imem_req, imem_addr, instr_valid);
        else passed++;
    endtask

    task automatic test_wrap();
        @(negedge clk);
        redirect        = 1'b1;
        redirect_target = 16'hFFFF;
        @(negedge clk);
        redirect = 1'b0;
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 16'hFFFF})
            $display("FAIL wrap_req_ffff: req=%b addr=%h need 1 ffff", imem_req, imem_addr);
        else passed++;
        @(negedge clk);
        checks++;
        if ({instr_valid, instruction, pc} !== {1'b1, 16'h0FFF, 16'hFFFF})
            $display("FAIL wrap_present: valid=%b instr=%h pc=%h need 1 0fff ffff", instr_valid, instruction, pc);
        else passed++;
        @(negedge clk);
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 16'h0000})
            $display("FAIL wrap_next: req=%b addr=%h need 1 0000", imem_req, imem_addr);
        else passed++;
        // async reset while a request is pending
        reset_n = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b0) $display("FAIL async_req_drop: req=%b need 0", imem_req);
        else passed++;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        checks          = 0;
        passed          = 0;
        mem_lat         = 0;
        ovr_en          = 1'b0;
        ovr_val         = 16'h0000;
        stall           = 1'b0;
        redirect        = 1'b0;
        redirect_target = 16'h0000;
        halt_cmd        = 1'b0;
        rst_cmd         = 1'b0;
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_in_fetch();
        test_halt();
        test_rst_cmd();
        test_wrap();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
